adc_avg_filter: RTL and testbench

- Downstream consumer of the 8-bit serial ADC reader's `value` output. That output is a level that changes at the ADC conversion rate, with no valid strobe.
- Samples the level at a fixed rate, rejects samples caught mid-update, and averages 2^AVG_SHIFT accepted samples.
- Emits a one-cycle `valid` strobe with each new mean, plus a hysteresis comparator flag for HAL/threshold use.
- Runs entirely in the system clock domain.

---
 rtl/adc_avg_filter.sv | 113 +++++++++++
 tb/tb_adc_avg_filter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_filter.sv
// adc_avg_filter: samples a quasi-static ADC level, rejects mid-update samples,
// averages 2^AVG_SHIFT accepted samples and drives a hysteresis comparator.
// Ports: clk, rst_n (async low), enable, value_in[7:0], threshold[7:0] ->
//        average[7:0], valid (1-cycle), above, sample_cnt[6:0].
module adc_avg_filter #(
  parameter int SAMPLE_DIV = 1250,
  parameter int AVG_SHIFT  = 3,
  parameter int HYST       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] value_in,
  input  logic [7:0] threshold,
  output logic [7:0] average,
  output logic       valid,
  output logic       above,
  output logic [6:0] sample_cnt
);

  localparam int ACC_W = 8 + AVG_SHIFT;
  localparam logic [15:0] DIV_LOAD = 16'(SAMPLE_DIV - 1);
  localparam logic [6:0] CNT_LAST = 7'((1 << AVG_SHIFT) - 1);
  localparam logic [8:0] HYST9 = 9'(HYST);
  localparam logic signed [9:0] HYST10 = 10'(HYST);

  logic [7:0] s1;
  logic [7:0] s2;
  logic [15:0] div;
  logic pending;
  logic [ACC_W-1:0] acc;

  logic tick;
  logic stable;
  logic accept;
  logic last;
  logic [ACC_W-1:0] sum;
  logic [7:0] mean;
  logic [8:0] hi;
  logic signed [9:0] lo;
  logic rise;
  logic fall;

  assign tick   = enable && (div == '0);
  // Two equal staged copies mean the level was not caught mid-update.
  assign stable = (s1 == s2);
  assign accept = enable && pending && stable;
  assign last   = (sample_cnt == CNT_LAST);
  assign sum    = acc + ACC_W'(s2);
  assign mean   = 8'(sum >> AVG_SHIFT);

  // Widened bounds: upper cannot wrap past 255, lower may go negative.
  assign hi   = {1'b0, threshold} + HYST9;
  assign lo   = $signed({2'b00, threshold}) - HYST10;
  assign rise = ({1'b0, mean} > hi);
  assign fall = ($signed({2'b00, mean}) < lo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= value_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= DIV_LOAD;
      pending <= 1'b0;
    end else if (!enable) begin
      div     <= DIV_LOAD;
      pending <= 1'b0;
    end else begin
      div <= tick ? DIV_LOAD : div - 16'd1;
      // A tick on the accept edge re-arms for the next sample.
      pending <= tick || (pending && !accept);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      sample_cnt <= '0;
      average    <= '0;
      valid      <= 1'b0;
      above      <= 1'b0;
    end else if (!enable) begin
      acc        <= '0;
      sample_cnt <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= accept && last;
      if (accept) begin
        if (last) begin
          acc        <= '0;
          sample_cnt <= '0;
          average    <= mean;
          if (rise) begin
            above <= 1'b1;
          end else if (fall) begin
            above <= 1'b0;
          end
        end else begin
          acc        <= sum;
          sample_cnt <= sample_cnt + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_avg_filter.sv
// tb_adc_avg_filter: randomized and directed checks of adc_avg_filter
// against a queue-based reference model of the sampling/averaging rules.
module tb_adc_avg_filter;

  localparam int SD = 4;
  localparam int SH = 3;
  localparam int HY = 4;
  localparam int N  = 1 << SH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] value_in = 8'd0;
  logic [7:0] threshold = 8'd50;
  logic [7:0] average;
  logic       valid;
  logic       above;
  logic [6:0] sample_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int vcount  = 0;

  adc_avg_filter #(
    .SAMPLE_DIV(SD),
    .AVG_SHIFT(SH),
    .HYST(HY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .value_in(value_in),
    .threshold(threshold),
    .average(average),
    .valid(valid),
    .above(above),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: level history, enabled-clock count, sample window.
  logic [7:0] hist[$];
  int win[$];
  int m_en;
  int m_accs = 0;
  bit m_pend;
  int e_avg;
  int e_valid;
  int e_above;

  function automatic void m_reset();
    hist = '{8'd0, 8'd0};
    win.delete();
    m_en = 0;
    m_pend = 0;
    e_avg = 0;
    e_valid = 0;
    e_above = 0;
  endfunction

  function automatic void m_step();
    bit tk;
    int s;
    int m;
    e_valid = 0;
    if (!enable) begin
      m_en = 0;
      m_pend = 0;
      win.delete();
    end else begin
      m_en++;
      tk = (m_en % SD) == 0;
      if (m_pend && hist[1] == hist[0]) begin
        win.push_back(int'(hist[0]));
        m_pend = 0;
        m_accs++;
        if (win.size() == N) begin
          s = 0;
          foreach (win[i]) s += win[i];
          m = s / N;
          e_avg = m;
          e_valid = 1;
          if (m > int'(threshold) + HY) e_above = 1;
          else if (m < int'(threshold) - HY) e_above = 0;
          win.delete();
        end
      end
      if (tk) m_pend = 1;
    end
    hist.push_back(value_in);
    void'(hist.pop_front());
  endfunction

  always @(negedge rst_n) m_reset();

  always @(posedge clk) if (rst_n) m_step();

  always @(negedge clk) begin
    chk("average", 32'(average), 32'(e_avg));
    chk("valid", 32'(valid), 32'(e_valid));
    chk("above", 32'(above), 32'(e_above));
    chk("sample_cnt", 32'(sample_cnt), 32'(win.size()));
    if (valid === 1'b1) vcount++;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic feed(input logic [7:0] v);
    int a0;
    int k;
    a0 = m_accs;
    k = 0;
    value_in = v;
    while (m_accs == a0 && k < 50) begin
      cyc();
      k++;
    end
    chk("feed_accept", 32'(m_accs), 32'(a0 + 1));
  endtask

  task automatic window(input logic [7:0] v);
    repeat (N) feed(v);
  endtask

  task automatic restart();
    enable = 1'b0;
    cyc();
    enable = 1'b1;
  endtask

  initial begin
    int v0;
    int r;
    int k;
    logic [7:0] tv[8];

    #1 rst_n = 1'b0;
    #1;
    chk("rst_average", 32'(average), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_above", 32'(above), 0);
    chk("rst_cnt", 32'(sample_cnt), 0);
    cyc(2);
    rst_n = 1'b1;
    enable = 1'b1;
    value_in = 8'd100;
    threshold = 8'd50;
    cyc(40);
    chk("basic_avg", 32'(average), 100);
    chk("basic_valid_n", 32'(vcount), 1);
    chk("basic_above", 32'(above), 1);

    restart();
    tv = '{8'd10, 8'd11, 8'd10, 8'd11, 8'd10, 8'd11, 8'd10, 8'd11};
    foreach (tv[i]) feed(tv[i]);
    chk("trunc_avg", 32'(average), 10);
    window(8'd255);
    chk("max_avg", 32'(average), 255);

    restart();
    v0 = vcount;
    k = 0;
    while (vcount == v0 && k < 30) begin
      repeat (6) begin
        value_in = (value_in == 8'd3) ? 8'd200 : 8'd3;
        cyc();
      end
      value_in = 8'd7;
      cyc(6);
      k++;
    end
    chk("glitch_valid", 32'(vcount), 32'(v0 + 1));
    chk("glitch_avg", 32'(average), 7);

    restart();
    threshold = 8'd128;
    window(8'd133);
    chk("hyst_133", 32'(above), 1);
    window(8'd129);
    chk("hyst_129", 32'(above), 1);
    window(8'd123);
    chk("hyst_123", 32'(above), 0);
    window(8'd127);
    chk("hyst_127", 32'(above), 0);
    threshold = 8'd253;
    window(8'd255);
    chk("hyst_nowrap", 32'(above), 0);
    threshold = 8'd2;
    window(8'd10);
    chk("hyst_set10", 32'(above), 1);
    window(8'd0);
    chk("hyst_noneg", 32'(above), 1);

    repeat (5) feed(8'd50);
    enable = 1'b0;
    cyc();
    chk("drop_cnt", 32'(sample_cnt), 0);
    chk("drop_avg", 32'(average), 0);
    chk("drop_above", 32'(above), 1);
    v0 = vcount;
    enable = 1'b1;
    repeat (N - 1) feed(8'd50);
    chk("reen_novalid", 32'(vcount), 32'(v0));
    feed(8'd50);
    chk("reen_valid", 32'(vcount), 32'(v0 + 1));
    chk("reen_avg", 32'(average), 50);

    repeat (3) feed(8'd60);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_avg", 32'(average), 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_above", 32'(above), 0);
    chk("arst_cnt", 32'(sample_cnt), 0);
    cyc(2);
    rst_n = 1'b1;
    v0 = vcount;
    repeat (N - 1) feed(8'd60);
    chk("arst_novalid", 32'(vcount), 32'(v0));
    feed(8'd60);
    chk("arst_valid_n", 32'(vcount), 32'(v0 + 1));
    chk("arst_avg_new", 32'(average), 60);

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        value_in = 8'($urandom);
      end else if (r < 11) begin
        for (int j = 0; j < 5; j++) begin
          value_in = ~value_in;
          cyc();
        end
      end else if (r == 11) begin
        enable = 1'b0;
      end else if (r < 15) begin
        enable = 1'b1;
      end else if (r == 15) begin
        threshold = 8'($urandom);
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
